// File: rtl/nbit_adder_pkg.sv
// Shared constants and helpers for the n-bit carry-lookahead adder.
package nbit_adder_pkg;

    // Width of one carry-lookahead block.
    localparam int CLA_W = 4;

    // Number of CLA blocks needed to cover an operand of the given width.
    function automatic int cla_blocks(input int width);
        return width / CLA_W;
    endfunction

endpackage

// File: rtl/nbit_adder_cla4.sv
// 4-bit carry-lookahead block: sum, carry-out and group propagate/generate.
module nbit_adder_cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout,
    output logic       pg,
    output logic       gg
);

    logic [3:0] w_p;
    logic [3:0] w_g;
    logic [4:0] w_c;

    // Bitwise propagate/generate and lookahead carries, all flat two-level terms.
    always_comb begin
        w_p    = a ^ b;
        w_g    = a & b;
        w_c[0] = cin;
        w_c[1] = w_g[0] | (w_p[0] & cin);
        w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
        w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
               | (w_p[2] & w_p[1] & w_p[0] & cin);
        gg     = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
        pg     = &w_p;
        w_c[4] = gg | (pg & cin);
        s      = w_p ^ w_c[3:0];
        cout   = w_c[4];
    end

endmodule

// File: rtl/nbit_adder.sv
// Registered n-bit adder: sum mod 2^n, carry-out and signed overflow, one-cycle latency.
module nbit_adder
    import nbit_adder_pkg::*;
#(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [n-1:0] A,
    input  logic [n-1:0] B,
    output logic         out_valid,
    output logic [n-1:0] Sum,
    output logic         cout,
    output logic         ovf
);

    localparam int NB = cla_blocks(n);

    // The block chain only works for whole 4-bit blocks.
    if ((n <= 0) || ((n % CLA_W) != 0)) begin : g_bad_width
        $error("nbit_adder: n must be a positive multiple of 4");
    end

    logic [n-1:0]  w_sum;
    logic [NB:0]   w_c;
    logic [NB-1:0] w_pg;
    logic [NB-1:0] w_gg;
    logic          w_ovf;
    // Group terms are available for a second lookahead level; the chain below ripples.
    logic          w_grp_unused;

    logic [n-1:0]  r_sum;
    logic          r_cout;
    logic          r_ovf;
    logic          r_valid;

    assign w_c[0] = 1'b0;

    for (genvar i = 0; i < NB; i++) begin : g_cla
        nbit_adder_cla4 u_cla4 (
            .a    (A[i*CLA_W +: CLA_W]),
            .b    (B[i*CLA_W +: CLA_W]),
            .cin  (w_c[i]),
            .s    (w_sum[i*CLA_W +: CLA_W]),
            .cout (w_c[i+1]),
            .pg   (w_pg[i]),
            .gg   (w_gg[i])
        );
    end

    assign w_grp_unused = ^{w_pg, w_gg};

    // Signed overflow: like-signed operands producing a result of the other sign.
    always_comb begin
        w_ovf = (A[n-1] == B[n-1]) && (w_sum[n-1] != A[n-1]);
    end

    // Output register: reset wins, valid loads a result, idle cycles hold the last one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_sum  <= w_sum;
                r_cout <= w_c[NB];
                r_ovf  <= w_ovf;
            end
        end
    end

    assign out_valid = r_valid;
    assign Sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_nbit_adder.sv
module tb_nbit_adder;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    exp_t exp_q[$];

    nbit_adder #(.n(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (a),
        .B         (b),
        .out_valid (out_valid),
        .Sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Drive one cycle of inputs just after an edge; a valid op is expected one edge later.
    task automatic drive(input logic v, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] esum, input logic ec, input logic eo);
        exp_t e;
        @(posedge clk);
        #1;
        in_valid = v;
        a        = av;
        b        = bv;
        if (v && rst_n) begin
            e.sum  = esum;
            e.cout = ec;
            e.ovf  = eo;
            e.cyc  = cyc + 1;
            exp_q.push_back(e);
        end
    endtask

    // Monitor: every presented result must match the oldest expected one.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", 64'(out_valid), 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("latency_cycle", 64'(cyc), 64'(e.cyc));
                chk("sum", 64'(sum), 64'(e.sum));
                chk("cout", 64'(cout), 64'(e.cout));
                chk("ovf", 64'(ovf), 64'(e.ovf));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [32:0] full;
        logic        ro;

        rst_n    = 1'b0;
        in_valid = 1'b1;
        a        = 32'd5;
        b        = 32'd7;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset_sum", 64'(sum), 64'd0);
        chk("reset_cout", 64'(cout), 64'd0);
        chk("reset_ovf", 64'(ovf), 64'd0);
        chk("reset_valid", 64'(out_valid), 64'd0);

        rst_n    = 1'b1;
        in_valid = 1'b0;

        // Basic, latency, carry, patterns, overflow.
        drive(1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0);
        drive(1'b1, 32'h0000_0001, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0);
        drive(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0);
        drive(1'b1, 32'h0000_FFFF, 32'hFFFF_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        drive(1'b1, 32'h1234_5678, 32'h8765_4321, 32'h9999_9999, 1'b0, 1'b0);
        drive(1'b1, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        drive(1'b1, 32'hAAAA_AAAA, 32'h5555_5555, 32'hFFFF_FFFF, 1'b0, 1'b0);
        drive(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1);
        drive(1'b1, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1);
        drive(1'b1, 32'h0000_000F, 32'h0000_0001, 32'h0000_0010, 1'b0, 1'b0);
        drive(1'b1, 32'h00FF_FFFF, 32'h0000_0001, 32'h0100_0000, 1'b0, 1'b0);

        // Hold: valid 3+4, then idle with different operands.
        drive(1'b1, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0);
        drive(1'b0, 32'd9, 32'd9, 32'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("hold_valid", 64'(out_valid), 64'd0);
        chk("hold_sum", 64'(sum), 64'd7);
        chk("hold_cout", 64'(cout), 64'd0);
        @(posedge clk);
        #1;
        chk("hold_sum_2", 64'(sum), 64'd7);

        // Reset asserted on the same edge as a valid op discards it.
        in_valid = 1'b1;
        a        = 32'hFFFF_FFFF;
        b        = 32'hFFFF_FFFF;
        rst_n    = 1'b0;
        @(posedge clk);
        #1;
        chk("midreset_valid", 64'(out_valid), 64'd0);
        chk("midreset_sum", 64'(sum), 64'd0);
        chk("midreset_cout", 64'(cout), 64'd0);
        rst_n    = 1'b1;
        in_valid = 1'b0;

        // Random back-to-back pairs against a plain 33-bit reference sum.
        for (int i = 0; i < 16; i++) begin
            ra   = $urandom();
            rb   = $urandom();
            full = {1'b0, ra} + {1'b0, rb};
            ro   = (ra[31] == rb[31]) && (full[31] != ra[31]);
            drive(1'b1, ra, rb, full[31:0], full[32], ro);
        end
        drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
